i2c_mem_controller: RTL and testbench

I2C_MEM_CONTROLLER -- requirements
Module: i2c_mem_controller

---
 rtl/i2c_mem_controller.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_mem_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mem_controller.sv
// i2c_mem_controller
//   Single-byte I2C master for memory-style subordinates. A write sends
//   START, {dev,0}, {0,mem}, wdata, STOP. A read sends START, {dev,0}, {0,mem},
//   repeated START, {dev,1}, then reads one byte and answers it with a NACK
//   before STOP.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               one-cycle request, accepted only when busy=0
//   rw                  1 = read one byte, 0 = write one byte
//   dev_addr, mem_addr  7-bit device and memory addresses
//   wdata               byte to write
//   busy, done          transaction in progress / one-cycle completion pulse
//   ack_err             a subordinate ACK slot read high (valid with done)
//   rdata               last successfully read byte
//   scl_out             1 = SCL released, 0 = SCL driven low
//   sda_in              SDA bus level (asynchronous, synchronised here)
//   sda_out, sda_en     SDA value and drive enable (sda_en=0 releases SDA)
module i2c_mem_controller #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [6:0] mem_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_out,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_en
);

  typedef enum logic [3:0] {
    IDLE, START, DEV_W, ACK_DW, MADDR, ACK_MA, WDATA, ACK_WD,
    RSTART, DEV_R, ACK_DR, RDATA, MNACK, STOP, FIN
  } state_t;

  localparam logic [15:0] QTERM = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] qcnt;
  logic [1:0]  ph;        // quarter within the current slot
  logic [2:0]  bcnt;      // bit within the current byte, wraps 7->0
  logic        rw_q;
  logic [6:0]  dev_q, mem_q;
  logic [7:0]  wdata_q;
  logic [7:0]  shreg;
  logic        ack_smp;
  logic        sda_s1, sda_s2;

  logic        accept, qtick, slot_end, smp, is_ack, is_byte, tx_bit;
  logic [7:0]  tx_byte;

  assign accept   = (state_q == IDLE) && start;
  assign qtick    = (state_q != IDLE) && (qcnt == QTERM);
  assign slot_end = qtick && (ph == 2'd3);
  assign smp      = qtick && (ph == 2'd2);
  assign is_ack   = (state_q == ACK_DW) || (state_q == ACK_MA) ||
                    (state_q == ACK_WD) || (state_q == ACK_DR);
  assign is_byte  = (state_q == DEV_W) || (state_q == MADDR) ||
                    (state_q == WDATA) || (state_q == DEV_R) ||
                    (state_q == RDATA);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tx_byte = '0;
    scl_out = 1'b1;
    sda_en  = 1'b0;
    sda_out = 1'b1;

    unique case (state_q)
      DEV_W:   tx_byte = {dev_q, 1'b0};
      MADDR:   tx_byte = {1'b0, mem_q};
      WDATA:   tx_byte = wdata_q;
      DEV_R:   tx_byte = {dev_q, 1'b1};
      default: tx_byte = '0;
    endcase
    tx_bit = tx_byte[3'd7 - bcnt];

    case (state_q)
      IDLE: if (start) state_d = START;
      START: begin
        // Q0 SDA high, Q1 SDA falls with SCL high, Q2/Q3 SCL low.
        scl_out = ~ph[1];
        sda_en  = 1'b1;
        sda_out = (ph == 2'd0);
        if (slot_end) state_d = DEV_W;
      end
      DEV_W, MADDR, WDATA, DEV_R: begin
        scl_out = ph[1];
        sda_en  = 1'b1;
        sda_out = tx_bit;
        if (slot_end && bcnt == 3'd7) begin
          case (state_q)
            DEV_W:   state_d = ACK_DW;
            MADDR:   state_d = ACK_MA;
            WDATA:   state_d = ACK_WD;
            default: state_d = ACK_DR;
          endcase
        end
      end
      ACK_DW, ACK_MA, ACK_WD, ACK_DR: begin
        scl_out = ph[1];
        if (slot_end) begin
          if (ack_smp || state_q == ACK_WD) state_d = STOP;
          else if (state_q == ACK_DW)       state_d = MADDR;
          else if (state_q == ACK_DR)       state_d = RDATA;
          else if (rw_q)                    state_d = RSTART;
          else                              state_d = WDATA;
        end
      end
      RSTART: begin
        // Q0 release SDA with SCL low, Q1 SCL high, Q2 SDA falls, Q3 SCL low.
        scl_out = (ph == 2'd1) || (ph == 2'd2);
        sda_en  = ph[1];
        sda_out = 1'b0;
        if (slot_end) state_d = DEV_R;
      end
      RDATA: begin
        scl_out = ph[1];
        if (slot_end && bcnt == 3'd7) state_d = MNACK;
      end
      MNACK: begin
        scl_out = ph[1];
        sda_en  = 1'b1;
        sda_out = 1'b1;
        if (slot_end) state_d = STOP;
      end
      STOP: begin
        // SDA low through Q0-Q2, SCL rises at Q2, SDA released at Q3.
        scl_out = ph[1];
        sda_en  = (ph != 2'd3);
        sda_out = 1'b0;
        if (slot_end) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt    <= '0;
      ph      <= '0;
      bcnt    <= '0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      mem_q   <= '0;
      wdata_q <= '0;
      shreg   <= '0;
      ack_smp <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      sda_s1  <= 1'b1;
      sda_s2  <= 1'b1;
    end else begin
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;

      if (state_q == IDLE) begin
        qcnt <= '0;
        ph   <= '0;
        bcnt <= '0;
      end else begin
        qcnt <= qtick ? '0 : qcnt + 16'd1;
        if (qtick) ph <= ph + 2'd1;
        if (slot_end && is_byte) bcnt <= bcnt + 3'd1;
      end

      if (accept) begin
        rw_q    <= rw;
        dev_q   <= dev_addr;
        mem_q   <= mem_addr;
        wdata_q <= wdata;
        ack_err <= 1'b0;
      end

      if (smp && is_ack) begin
        ack_smp <= sda_s2;
        if (sda_s2) ack_err <= 1'b1;
      end

      if (smp && state_q == RDATA) shreg <= {shreg[6:0], sda_s2};
      if (slot_end && state_q == RDATA && bcnt == 3'd7) rdata <= shreg;
    end
  end

endmodule

// File: tb/tb_i2c_mem_controller.sv
// Directed bench for i2c_mem_controller with a bus-level subordinate model.
module tb_i2c_mem_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [6:0] mem_addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, ack_err, scl_out, sda_out, sda_en;
  logic [7:0] rdata;
  logic       sda_bus;

  always #5 clk = ~clk;

  i2c_mem_controller #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw),
    .dev_addr(dev_addr), .mem_addr(mem_addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl_out(scl_out), .sda_in(sda_bus), .sda_out(sda_out), .sda_en(sda_en)
  );

  // Subordinate: open-drain pull-low on SDA, pull-up otherwise.
  logic       sub_drv_low = 1'b0;
  bit         nack_dev = 1'b0;
  logic [7:0] read_val = 8'h3C;
  assign sda_bus = sda_en ? sda_out : ~sub_drv_low;

  int start_cnt = 0;
  always @(negedge sda_bus) if (scl_out === 1'b1) start_cnt++;

  int         seen_start = 0, fall_n = 0, byte_idx = 0;
  bit         sending = 1'b0, is_read = 1'b0;
  logic [7:0] rx_sh = '0, tx_sh = '0;
  logic [7:0] rx_bytes [$];

  always @(posedge scl_out)
    if (!sending && fall_n >= 0 && fall_n < 8) rx_sh = {rx_sh[6:0], sda_bus};

  always @(negedge scl_out) begin
    if (start_cnt != seen_start) begin
      seen_start  = start_cnt;
      fall_n      = 0;
      byte_idx    = 0;
      sending     = 1'b0;
      sub_drv_low = 1'b0;
    end else begin
      fall_n++;
      if (fall_n == 8) begin
        if (sending) sub_drv_low = 1'b0;
        else begin
          rx_bytes.push_back(rx_sh);
          if (byte_idx == 0) is_read = rx_sh[0];
          sub_drv_low = !(byte_idx == 0 && nack_dev);
        end
      end else if (fall_n == 9) begin
        sub_drv_low = 1'b0;
        fall_n = 0;
        if (is_read && !sending && byte_idx == 0) begin
          sending     = 1'b1;
          tx_sh       = read_val;
          sub_drv_low = !tx_sh[7];
        end
        byte_idx++;
      end else if (sending && fall_n < 8) begin
        sub_drv_low = !tx_sh[3'(7 - fall_n)];
      end
    end
  end

  // SDA edges while SCL stays high: falls are (re)starts, rises are stops.
  int   hi_falls = 0, hi_rises = 0, done_cnt = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  always @(negedge clk) begin
    if (prev_scl === 1'b1 && scl_out === 1'b1 && sda_bus !== prev_sda) begin
      if (sda_bus === 1'b0) hi_falls++;
      else                  hi_rises++;
    end
    prev_scl = scl_out;
    prev_sda = sda_bus;
    if (done === 1'b1) done_cnt++;
  end

  int ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic chk_rx(input string tag, input int base, input int n,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] exp_b [3];
    logic [7:0] obs;
    exp_b = '{e0, e1, e2};
    chk({tag, "_count"}, 32'(rx_bytes.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      obs = (base + i < rx_bytes.size()) ? rx_bytes[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(exp_b[i]));
    end
  endtask

  task automatic launch(input logic r, input logic [6:0] d, input logic [6:0] m, input logic [7:0] w);
    @(negedge clk);
    rw = r; dev_addr = d; mem_addr = m; wdata = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  int base, f0, r0, d0;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    chk("rst_rdata",   32'(rdata), 0);
    chk("rst_scl",     32'(scl_out), 1);
    chk("rst_sda_en",  32'(sda_en), 0);
    chk("rst_sda_out", 32'(sda_out), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xA5 to 0x50:0x12
    base = rx_bytes.size(); f0 = hi_falls; r0 = hi_rises; d0 = done_cnt;
    launch(1'b0, 7'h50, 7'h12, 8'hA5);
    wait_done("wr_done_timeout");
    chk("wr_ack_err", 32'(ack_err), 0);
    repeat (2) @(negedge clk);
    chk("wr_busy_after", 32'(busy), 0);
    chk("wr_done_cnt", 32'(done_cnt - d0), 1);
    chk_rx("wr", base, 3, 8'hA0, 8'h12, 8'hA5);
    chk("wr_starts", 32'(hi_falls - f0), 1);
    chk("wr_stops",  32'(hi_rises - r0), 1);
    chk("wr_rdata",  32'(rdata), 0);

    // Read from 0x50:0x7F, subordinate returns 0x3C
    base = rx_bytes.size(); f0 = hi_falls; r0 = hi_rises;
    read_val = 8'h3C;
    launch(1'b1, 7'h50, 7'h7F, 8'h00);
    wait_done("rd_done_timeout");
    chk("rd_ack_err", 32'(ack_err), 0);
    chk("rd_rdata", 32'(rdata), 32'h3C);
    repeat (2) @(negedge clk);
    chk_rx("rd", base, 3, 8'hA0, 8'h7F, 8'hA1);
    chk("rd_starts", 32'(hi_falls - f0), 2);
    chk("rd_stops",  32'(hi_rises - r0), 1);

    // Device-address NACK
    base = rx_bytes.size(); f0 = hi_falls; r0 = hi_rises;
    nack_dev = 1'b1;
    launch(1'b0, 7'h50, 7'h12, 8'h99);
    wait_done("nack_done_timeout");
    chk("nack_ack_err", 32'(ack_err), 1);
    repeat (20) @(negedge clk);
    nack_dev = 1'b0;
    chk("nack_ack_err_hold", 32'(ack_err), 1);
    chk("nack_rdata", 32'(rdata), 32'h3C);
    chk_rx("nack", base, 1, 8'hA0, 8'h00, 8'h00);
    chk("nack_starts", 32'(hi_falls - f0), 1);
    chk("nack_stops",  32'(hi_rises - r0), 1);

    // Start while busy and input changes are ignored
    base = rx_bytes.size(); f0 = hi_falls; d0 = done_cnt;
    launch(1'b0, 7'h50, 7'h33, 8'h5A);
    chk("ack_err_cleared", 32'(ack_err), 0);
    repeat (100) @(negedge clk);
    rw = 1'b1; dev_addr = 7'h11; mem_addr = 7'h22; wdata = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_done_timeout");
    chk("ign_ack_err", 32'(ack_err), 0);
    repeat (30) @(negedge clk);
    chk("ign_done_cnt", 32'(done_cnt - d0), 1);
    chk_rx("ign", base, 3, 8'hA0, 8'h33, 8'h5A);
    chk("ign_starts", 32'(hi_falls - f0), 1);

    // Reset during the data byte of a write
    d0 = done_cnt;
    launch(1'b0, 7'h50, 7'h44, 8'hC3);
    for (int i = 0; i < 3000; i++) begin
      if (byte_idx == 2 && fall_n == 4 && !sending) break;
      @(negedge clk);
    end
    chk("mid_reached", 32'(byte_idx == 2 && fall_n == 4), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_scl",    32'(scl_out), 1);
    chk("mid_sda_en", 32'(sda_en), 0);
    chk("mid_busy",   32'(busy), 0);
    chk("mid_rdata",  32'(rdata), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_no_done", 32'(done_cnt - d0), 0);
    chk("mid_busy_after", 32'(busy), 0);

    // Normal write after the abandoned one
    base = rx_bytes.size(); f0 = hi_falls; r0 = hi_rises;
    launch(1'b0, 7'h50, 7'h01, 8'h7E);
    wait_done("post_done_timeout");
    chk("post_ack_err", 32'(ack_err), 0);
    repeat (2) @(negedge clk);
    chk_rx("post", base, 3, 8'hA0, 8'h01, 8'h7E);
    chk("post_starts", 32'(hi_falls - f0), 1);
    chk("post_stops",  32'(hi_rises - r0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
